// File: rtl/pipeline_run_controller.sv
// pipeline_run_controller: global pipeline enable sequencing for run, step, halt-drain and done,
// plus a saturating count of enabled cycles.
module pipeline_run_controller #(
    parameter int NB_CYCLES    = 32,
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_STATE     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_run,
    input  logic                 i_step,
    input  logic                 i_halt_id,
    input  logic                 i_stall,
    output logic                 o_enable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [NB_CYCLES-1:0] o_cycle_count,
    output logic [NB_STATE-1:0]  o_state
);
    localparam int NB_DRAIN = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;

    typedef enum logic [NB_STATE-1:0] {
        IDLE  = NB_STATE'(0),
        RUN   = NB_STATE'(1),
        STEP  = NB_STATE'(2),
        DRAIN = NB_STATE'(3),
        DONE  = NB_STATE'(4)
    } state_t;

    state_t              state, next_state;
    logic [NB_DRAIN-1:0] drain_cnt, next_drain;
    logic                halt_acc;

    assign o_enable = state == RUN || state == STEP || state == DRAIN;
    assign o_busy   = o_enable;
    assign o_done   = state == DONE;
    assign o_state  = state;
    // A HALT held in ID by a load-use stall is only taken once the stall clears.
    assign halt_acc = i_halt_id & o_enable & ~i_stall;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            drain_cnt     <= '0;
            o_cycle_count <= '0;
        end else begin
            state         <= next_state;
            drain_cnt     <= next_drain;
            o_cycle_count <= o_enable && ~&o_cycle_count ? o_cycle_count + NB_CYCLES'(1) : o_cycle_count;
        end
    end

    always_comb begin
        next_state = state;
        next_drain = drain_cnt;
        case (state)
            IDLE: next_state = i_run ? RUN : i_step ? STEP : IDLE;
            RUN, STEP: begin
                next_state = halt_acc ? (DRAIN_CYCLES == 0 ? DONE : DRAIN) : state == RUN ? RUN : IDLE;
                next_drain = halt_acc ? NB_DRAIN'(DRAIN_CYCLES) : drain_cnt;
            end
            // The last granted drain cycle is the one where the counter reads 1.
            DRAIN: begin
                next_drain = drain_cnt - NB_DRAIN'(1);
                next_state = drain_cnt <= NB_DRAIN'(1) ? DONE : DRAIN;
            end
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pipeline_run_controller.sv
// tb_pipeline_run_controller: directed scenarios with literal expectations plus random stimulus
// checked every cycle against a flag/counter model of the run controller.
module tb_pipeline_run_controller;
    localparam int DRAIN = 3;

    logic        i_clk = 0, i_reset = 1, i_run = 0, i_step = 0, i_halt_id = 0, i_stall = 0;
    logic        o_enable, o_busy, o_done;
    logic [31:0] o_cycle_count;
    logic [2:0]  o_state;
    logic        s_enable, s_busy, s_done;
    logic [3:0]  s_cycle_count;
    logic [2:0]  s_state;
    int          vectors = 0, miscompares = 0;

    bit          m_run, m_step, m_done, m_live;
    int          m_drain;
    longint      m_count;

    always #5 i_clk = ~i_clk;

    pipeline_run_controller dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_halt_id(i_halt_id), .i_stall(i_stall), .o_enable(o_enable), .o_busy(o_busy),
        .o_done(o_done), .o_cycle_count(o_cycle_count), .o_state(o_state)
    );

    pipeline_run_controller #(.NB_CYCLES(4)) dut_s (
        .i_clk(i_clk), .i_reset(i_reset), .i_run(i_run), .i_step(i_step),
        .i_halt_id(i_halt_id), .i_stall(i_stall), .o_enable(s_enable), .o_busy(s_busy),
        .o_done(s_done), .o_cycle_count(s_cycle_count), .o_state(s_state)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_en();
        return m_run | m_step | (m_drain > 0);
    endfunction

    function automatic int m_state();
        return m_done ? 4 : m_drain > 0 ? 3 : m_step ? 2 : m_run ? 1 : 0;
    endfunction

    // Reference model: flags for running/stepping/done plus remaining drain cycles.
    always @(posedge i_clk) begin : model
        bit halt;
        if (i_reset) begin
            {m_run, m_step, m_done} = 3'b000;
            m_drain = 0;
            m_count = 0;
            m_live  = 1;
        end else begin
            halt = i_halt_id & m_en() & ~i_stall;
            if (m_en() && m_count < 64'hFFFF_FFFF) m_count = m_count + 1;
            if (m_drain > 0) begin
                m_drain = m_drain - 1;
                if (m_drain == 0) m_done = 1;
            end else if ((m_run || m_step) && halt) begin
                m_run  = 0;
                m_step = 0;
                if (DRAIN == 0) m_done = 1;
                else m_drain = DRAIN;
            end else if (m_step) m_step = 0;
            else if (!m_run && !m_done) begin
                if (i_run) m_run = 1;
                else if (i_step) m_step = 1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (m_live) begin
            chk("enable", o_enable, m_en());
            chk("busy", o_busy, m_en());
            chk("done", o_done, m_done);
            chk("state", o_state, m_state());
            chk("count", o_cycle_count, m_count);
            chk("sat_enable", s_enable, m_en());
            chk("sat_count", s_cycle_count, m_count > 15 ? 15 : m_count);
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit h, input bit st);
        i_run     = r;
        i_step    = s;
        i_halt_id = h;
        i_stall   = st;
        tick();
    endtask

    task automatic do_reset();
        i_reset = 1;
        drive(1, 0, 0, 0);
        chk("rst_state", o_state, 0);
        chk("rst_count", o_cycle_count, 0);
        drive(1, 0, 0, 0);
        chk("rst_enable", o_enable, 0);
        chk("rst_done", o_done, 0);
        i_reset = 0;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("rst_idle", o_state, 0);
        chk("rst_busy", o_busy, 0);
    endtask

    initial begin
        do_reset();
        for (int c = 0; c < 35; c++) begin
            chk("rth_en", o_enable, c >= 1 && c <= 13);
            chk("rth_done", o_done, c >= 14);
            drive(c == 0, 0, c == 10, 0);
        end
        chk("rth_count", o_cycle_count, 13);
        chk("rth_state", o_state, 4);

        do_reset();
        for (int c = 0; c < 12; c++) begin
            chk("step_en", o_enable, c == 1 || c == 5 || c == 9);
            chk("step_state", o_state, (c == 1 || c == 5 || c == 9) ? 2 : 0);
            drive(0, c == 0 || c == 4 || c == 8, 0, 0);
        end
        chk("step_count", o_cycle_count, 3);

        do_reset();
        for (int c = 0; c < 15; c++) begin
            chk("stall_en", o_enable, c >= 1 && c <= 10);
            chk("stall_done", o_done, c >= 11);
            chk("stall_drain", o_state == 3, c >= 8 && c <= 10);
            drive(c == 0, 0, c >= 5 && c <= 7, c == 5 || c == 6);
        end
        chk("stall_count", o_cycle_count, 10);

        do_reset();
        for (int c = 0; c < 15; c++) begin
            chk("sim_state", o_state, c == 0 ? 0 : c <= 5 ? 1 : c <= 8 ? 3 : 4);
            drive(c == 0 || c == 12, c == 0 || c == 3, c == 5, 0);
        end

        do_reset();
        for (int c = 0; c < 8; c++) begin
            chk("rmd_state", o_state, c == 0 ? 0 : c <= 2 ? 1 : c <= 4 ? 3 : 0);
            if (c == 5) chk("rmd_count", o_cycle_count, 0);
            i_reset = c == 4;
            drive(c == 0, 0, c == 2, 0);
        end
        i_reset = 0;

        do_reset();
        for (int c = 0; c < 23; c++) begin
            if (c == 21) begin
                chk("sat_hold", s_cycle_count, 15);
                chk("wide_count", o_cycle_count, 20);
            end
            drive(c == 0, 0, 0, 0);
        end

        do_reset();
        repeat (4000) begin
            i_reset = $urandom_range(149) == 0;
            drive($urandom_range(15) == 0, $urandom_range(7) == 0,
                  $urandom_range(11) == 0, $urandom_range(3) == 0);
        end
        i_reset = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Sequences the five-stage MIPS pipeline (IF/ID/EX/MEM/WB) by generating the single global enable for the PC, all stage registers, the register file and data-memory writes. It supports free-running execution, single-cycle stepping and orderly termination: a HALT decoded in ID drains the older instructions through WB before the pipeline freezes. It sits between the debug/UART command unit and the datapath. It counts executed cycles for reporting.

## Interface
Parameters:
- NB_CYCLES, 32, width of the executed-cycle counter
- DRAIN_CYCLES, 3, enabled cycles granted after a HALT is accepted so older instructions retire through WB
- NB_STATE, 3, state encoding width

Ports:
- i_clk  in  1  system clock, rising edge
- i_reset  in  1  reset i_reset, synchronous, active-high
- i_run  in  1  single-cycle pulse from debug unit: start continuous execution
- i_step  in  1  single-cycle pulse from debug unit: execute exactly one clock
- i_halt_id  in  1  HALT instruction currently in ID stage
- i_stall  in  1  load-use stall from hazard detection; ID is being held this cycle
- o_enable  out  1  global pipeline enable
- o_busy  out  1  high in RUN, STEP, DRAIN
- o_done  out  1  high in DONE
- o_cycle_count  out  NB_CYCLES  number of cycles with o_enable=1
- o_state  out  NB_STATE  current state, for debug readout

## Operation
- States and encodings: IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4. Unused encodings go to IDLE on the next edge.
- Outputs are Moore decodes of state and registers. There is no combinational path from any input to any output.
  - o_enable=1 in RUN, STEP and DRAIN.
  - o_busy equals o_enable.
  - o_done=1 only in DONE.
- Halt acceptance: halt_acc = i_halt_id & o_enable & ~i_stall.
  - A HALT held in ID by a load-use stall is not accepted until the stall clears.
- IDLE:
  - i_run moves to RUN.
  - Otherwise, i_step moves to STEP.
  - i_run has priority when both are high.
- RUN:
  - halt_acc moves to DRAIN and loads drain_cnt with DRAIN_CYCLES.
  - Otherwise stays in RUN.
  - i_run and i_step are ignored.
- STEP:
  - halt_acc moves to DRAIN and loads drain_cnt with DRAIN_CYCLES.
  - Otherwise returns to IDLE.
  - Drain always runs free, even when the HALT was reached by stepping.
- DRAIN:
  - drain_cnt decrements each cycle.
  - When drain_cnt==1, moves to DONE on that edge. The enabled DRAIN cycles therefore total exactly DRAIN_CYCLES.
  - i_halt_id, i_run and i_step are ignored.
  - If DRAIN_CYCLES==0, halt_acc goes directly to DONE.
- DONE: sticky. Only i_reset leaves it. i_run and i_step are ignored.
- o_cycle_count:
  - Increments on every edge where o_enable=1.
  - Saturates at 2^NB_CYCLES-1; it does not wrap.
- Reset (any state, including mid-DRAIN or mid-STEP):
  - state=IDLE, drain_cnt=0, o_cycle_count=0.
  - Hence o_enable=0, o_busy=0, o_done=0, o_state=0.
  - Reset wins over every simultaneous input.

## Timing
- i_run or i_step sampled high at edge k in IDLE: o_enable high in the cycle after edge k. One-cycle latency.
- Step: o_enable is high for exactly one cycle per accepted i_step pulse. i_step pulses arriving outside IDLE are dropped, not queued.
- Halt accepted at edge k (RUN or STEP): o_enable stays high for cycles k+1 … k+DRAIN_CYCLES. o_done rises and o_enable falls in cycle k+DRAIN_CYCLES+1.
- The cycle in which halt_acc is true is itself enabled and counted. The HALT moves into EX on that edge.
- o_cycle_count is updated at the same edge that consumes the enabled cycle. It is readable one cycle later.

## Test plan
- Reset: assert i_reset 2 cycles with i_run=1 -> o_enable=0, o_busy=0, o_done=0, o_state=0, o_cycle_count=0; after release with i_run=0, remains IDLE.
- Stepping: 3 i_step pulses spaced 4 cycles apart -> exactly 3 single-cycle o_enable pulses, each one cycle after its i_step; o_cycle_count=3; state returns to 0 after each pulse.
- Run to halt: i_run at cycle 0, i_halt_id high at cycle 10 -> o_enable high cycles 1–13, o_done=1 from cycle 14, o_cycle_count=13, o_state=4, held for 20 further cycles.
- Halt during stall: in RUN, i_halt_id and i_stall both high cycles 5–6, i_stall low at cycle 7 -> DRAIN entered at the cycle 7 edge (not 5), o_done at cycle 11.
- Simultaneous and ignored inputs:
  - i_run=i_step=1 in IDLE -> RUN.
  - i_step during RUN -> no effect.
  - i_run in DONE -> stays DONE.
- Reset mid-DRAIN plus saturation:
  - Reset during 2nd DRAIN cycle -> IDLE, counter 0.
  - With NB_CYCLES=4, run 20 cycles -> o_cycle_count holds 15.
